// File: rtl/mod_exp_pkg.sv
// Shared constants and FSM encodings for the mod_exp modular exponentiation engine.
package mod_exp_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int NUM_WORDS  = 64;

  typedef enum logic [4:0] {
    INIT_STATE       = 5'd0,
    LOAD_M_E         = 5'd1,
    LOAD_N           = 5'd2,
    WAIT_COMPUTE     = 5'd3,
    CALC_M_BAR       = 5'd4,
    GET_K_E          = 5'd5,
    BIGLOOP          = 5'd6,
    CALC_C_BAR_M_BAR = 5'd7,
    CALC_C_BAR_1     = 5'd8,
    COMPLETE         = 5'd9,
    OUTPUT_RESULT    = 5'd10,
    TERMINAL         = 5'd11
  } exp_state_t;

  typedef enum logic [3:0] {
    MM_IDLE = 4'd0,
    MM_MUL  = 4'd1,
    MM_RED  = 4'd2,
    MM_SUB  = 4'd3,
    MM_DONE = 4'd4
  } mm_state_t;

endpackage

// File: rtl/mod_exp_mont_mul.sv
// Word-serial CIOS Montgomery multiplier: result = a*b*2^-(DATA_WIDTH*NUM_WORDS) mod n.
// Optional MODEXP_ASSERT_EN adds a simulation check that every result is below n.
module mont_mul
  import mod_exp_pkg::*;
#(
  parameter int DATA_WIDTH = mod_exp_pkg::DATA_WIDTH,
  parameter int NUM_WORDS  = mod_exp_pkg::NUM_WORDS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] a,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] b,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] n,
  input  logic [DATA_WIDTH-1:0]           nprime0,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] result,
  output logic                            done,
  output logic [3:0]                      state
);

  localparam int DW = DATA_WIDTH;
  localparam int NW = NUM_WORDS;
  localparam int CW = $clog2(NW);
  localparam int IW = $clog2(NW + 2);

  mm_state_t       st_q, st_nxt;
  logic [CW-1:0]   i_cnt, j_cnt;
  logic            mstep, borrow, use_diff;
  logic [DW-1:0]   acc_w [NW+2];
  logic [DW-1:0]   dif_w [NW];
  logic [DW-1:0]   m_q, carry;
  logic [DW-1:0]   a_word, b_word, n_word, t_word;
  logic [DW-1:0]   mul_x, mul_y, mul_add;
  logic [2*DW-1:0] mac;
  logic [DW:0]     fold, diff;
  logic            last_j, last_i;

  assign a_word = a[int'(j_cnt)*DW +: DW];
  assign b_word = b[int'(i_cnt)*DW +: DW];
  assign n_word = n[int'(j_cnt)*DW +: DW];
  assign t_word = acc_w[IW'(j_cnt)];
  assign last_j = (j_cnt == CW'(NW - 1));
  assign last_i = (i_cnt == CW'(NW - 1));
  assign done   = (st_q == MM_DONE);
  assign state  = st_q;

  // The single multiplier serves a[j]*b[i], the per-row m = t0*n', and m*n[j].
  always_comb begin
    mul_x   = a_word;
    mul_y   = b_word;
    mul_add = t_word;
    if (st_q == MM_RED) begin
      if (mstep) begin
        mul_x   = t_word;
        mul_y   = nprime0;
        mul_add = '0;
      end else begin
        mul_x = m_q;
        mul_y = n_word;
      end
    end
    mac  = {{DW{1'b0}}, mul_x} * {{DW{1'b0}}, mul_y}
         + {{DW{1'b0}}, mul_add} + {{DW{1'b0}}, carry};
    fold = {1'b0, acc_w[NW]} + {1'b0, mac[2*DW-1:DW]};
    diff = {1'b0, t_word} - {1'b0, n_word} - {{DW{1'b0}}, borrow};
  end

  always_comb begin
    st_nxt = st_q;
    case (st_q)
      MM_IDLE: if (start) st_nxt = MM_MUL;
      MM_MUL:  if (last_j) st_nxt = MM_RED;
      MM_RED:  if (!mstep && last_j) st_nxt = last_i ? MM_SUB : MM_MUL;
      MM_SUB:  if (last_j) st_nxt = MM_DONE;
      MM_DONE: st_nxt = MM_IDLE;
      default: st_nxt = MM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= MM_IDLE;
      i_cnt    <= '0;
      j_cnt    <= '0;
      mstep    <= 1'b0;
      borrow   <= 1'b0;
      use_diff <= 1'b0;
      m_q      <= '0;
      carry    <= '0;
      for (int k = 0; k < NW + 2; k++) acc_w[k] <= '0;
      for (int k = 0; k < NW; k++) dif_w[k] <= '0;
    end else begin
      st_q <= st_nxt;
      case (st_q)
        MM_IDLE: if (start) begin
          for (int k = 0; k < NW + 2; k++) acc_w[k] <= '0;
          i_cnt <= '0;
          j_cnt <= '0;
          carry <= '0;
          mstep <= 1'b0;
        end
        MM_MUL: begin
          acc_w[IW'(j_cnt)] <= mac[DW-1:0];
          carry             <= mac[2*DW-1:DW];
          j_cnt             <= j_cnt + CW'(1);
          if (last_j) begin
            acc_w[NW]   <= fold[DW-1:0];
            acc_w[NW+1] <= {{(DW-1){1'b0}}, fold[DW]};
            j_cnt       <= '0;
            carry       <= '0;
            mstep       <= 1'b1;
          end
        end
        MM_RED: begin
          if (mstep) begin
            m_q   <= mac[DW-1:0];
            mstep <= 1'b0;
          end else begin
            // Row reduction shifts the accumulator down one word as it goes.
            if (j_cnt != '0) acc_w[IW'(j_cnt - CW'(1))] <= mac[DW-1:0];
            carry <= mac[2*DW-1:DW];
            j_cnt <= j_cnt + CW'(1);
            if (last_j) begin
              acc_w[NW-1] <= fold[DW-1:0];
              acc_w[NW]   <= acc_w[NW+1] + {{(DW-1){1'b0}}, fold[DW]};
              j_cnt       <= '0;
              carry       <= '0;
              borrow      <= 1'b0;
              i_cnt       <= last_i ? '0 : i_cnt + CW'(1);
            end
          end
        end
        MM_SUB: begin
          dif_w[j_cnt] <= diff[DW-1:0];
          borrow       <= diff[DW];
          j_cnt        <= j_cnt + CW'(1);
          if (last_j) begin
            use_diff <= (acc_w[NW] != '0) || !diff[DW];
            j_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < NW; k++) begin : g_res
    assign result[k*DW +: DW] = use_diff ? dif_w[k] : acc_w[k];
  end

`ifdef MODEXP_ASSERT_EN
  a_res_lt_n: assert property (@(posedge clk) disable iff (reset) done |-> (result < n));
`endif

endmodule

// File: rtl/mod_exp.sv
// Montgomery-ladder-free left-to-right modular exponentiation C = M^E mod N with streamed operands.
// Optional MODEXP_ASSERT_EN enables simulation assertions on N, nprime0 and the FSM range.
module mod_exp
  import mod_exp_pkg::*;
#(
  parameter int DATA_WIDTH = mod_exp_pkg::DATA_WIDTH,
  parameter int NUM_WORDS  = mod_exp_pkg::NUM_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] m_buf,
  input  logic [DATA_WIDTH-1:0] e_buf,
  input  logic [DATA_WIDTH-1:0] n_buf,
  input  logic [DATA_WIDTH-1:0] r_buf,
  input  logic [DATA_WIDTH-1:0] t_buf,
  input  logic [DATA_WIDTH-1:0] nprime0,
  input  logic                  startInput,
  input  logic                  startCompute,
  input  logic                  getResult,
  output logic [4:0]            exp_state,
  output logic [3:0]            state,
  output logic [DATA_WIDTH-1:0] res_out
);

  localparam int DW = DATA_WIDTH;
  localparam int NW = NUM_WORDS;
  localparam int OW = DW * NW;
  localparam int CW = $clog2(NW);
  localparam int BW = $clog2(OW);

  exp_state_t     st_q, st_nxt;
  logic [OW-1:0]  m_reg, e_reg, n_reg, r_reg, t_reg;
  logic [OW-1:0]  m_bar, c_bar, c_res;
  logic [OW-1:0]  mm_a, mm_b, mm_res;
  logic [DW-1:0]  nprime_q;
  logic [CW-1:0]  wcnt;
  logic [BW-1:0]  bit_idx, msb;
  logic           e_zero, mm_op, mm_busy, mm_start, mm_done;
  logic           unused_get_result;

  assign unused_get_result = getResult;
  assign exp_state         = st_q;

  always_comb begin
    msb    = '0;
    e_zero = (e_reg == '0);
    for (int k = 0; k < OW; k++)
      if (e_reg[k]) msb = BW'(k);
  end

  always_comb begin
    st_nxt = st_q;
    mm_a   = '0;
    mm_b   = '0;
    mm_op  = 1'b0;
    case (st_q)
      INIT_STATE:   if (startInput) st_nxt = LOAD_M_E;
      LOAD_M_E:     if (startInput && wcnt == CW'(NW - 1)) st_nxt = LOAD_N;
      LOAD_N:       st_nxt = WAIT_COMPUTE;
      WAIT_COMPUTE: if (startCompute) st_nxt = CALC_M_BAR;
      CALC_M_BAR: begin
        mm_op = 1'b1;
        mm_a  = m_reg;
        mm_b  = t_reg;
        if (mm_done) st_nxt = GET_K_E;
      end
      GET_K_E: st_nxt = e_zero ? CALC_C_BAR_1 : BIGLOOP;
      BIGLOOP: begin
        mm_op = 1'b1;
        mm_a  = c_bar;
        mm_b  = c_bar;
        if (mm_done) begin
          if (e_reg[bit_idx])       st_nxt = CALC_C_BAR_M_BAR;
          else if (bit_idx == '0)   st_nxt = CALC_C_BAR_1;
        end
      end
      CALC_C_BAR_M_BAR: begin
        mm_op = 1'b1;
        mm_a  = c_bar;
        mm_b  = m_bar;
        if (mm_done) st_nxt = (bit_idx == '0) ? CALC_C_BAR_1 : BIGLOOP;
      end
      CALC_C_BAR_1: begin
        mm_op = 1'b1;
        mm_a  = c_bar;
        mm_b  = {{(OW-1){1'b0}}, 1'b1};
        if (mm_done) st_nxt = COMPLETE;
      end
      COMPLETE:      if (startCompute) st_nxt = OUTPUT_RESULT;
      OUTPUT_RESULT: if (wcnt == CW'(NW - 1)) st_nxt = TERMINAL;
      TERMINAL:      ;
      default:       st_nxt = INIT_STATE;
    endcase
  end

  // One multiplier launch per visit; busy drops on done so a repeated BIGLOOP relaunches.
  assign mm_start = mm_op && !mm_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= INIT_STATE;
      m_reg    <= '0;
      e_reg    <= '0;
      n_reg    <= '0;
      r_reg    <= '0;
      t_reg    <= '0;
      m_bar    <= '0;
      c_bar    <= '0;
      c_res    <= '0;
      nprime_q <= '0;
      wcnt     <= '0;
      bit_idx  <= '0;
      mm_busy  <= 1'b0;
      res_out  <= '0;
    end else begin
      st_q <= st_nxt;
      if (mm_start)     mm_busy <= 1'b1;
      else if (mm_done) mm_busy <= 1'b0;
      case (st_q)
        INIT_STATE: wcnt <= '0;
        LOAD_M_E: if (startInput) begin
          m_reg <= {m_buf, m_reg[OW-1:DW]};
          e_reg <= {e_buf, e_reg[OW-1:DW]};
          n_reg <= {n_buf, n_reg[OW-1:DW]};
          r_reg <= {r_buf, r_reg[OW-1:DW]};
          t_reg <= {t_buf, t_reg[OW-1:DW]};
          wcnt  <= wcnt + CW'(1);
        end
        LOAD_N: nprime_q <= nprime0;
        CALC_M_BAR: if (mm_done) begin
          m_bar <= mm_res;
          c_bar <= r_reg;
        end
        GET_K_E: bit_idx <= msb;
        BIGLOOP: if (mm_done) begin
          c_bar <= mm_res;
          if (!e_reg[bit_idx] && bit_idx != '0) bit_idx <= bit_idx - BW'(1);
        end
        CALC_C_BAR_M_BAR: if (mm_done) begin
          c_bar <= mm_res;
          if (bit_idx != '0) bit_idx <= bit_idx - BW'(1);
        end
        CALC_C_BAR_1: if (mm_done) begin
          c_res <= mm_res;
          wcnt  <= '0;
        end
        OUTPUT_RESULT: begin
          res_out <= c_res[DW-1:0];
          c_res   <= c_res >> DW;
          wcnt    <= wcnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  mont_mul #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_WORDS (NUM_WORDS)
  ) u_mm (
    .clk    (clk),
    .reset  (reset),
    .start  (mm_start),
    .a      (mm_a),
    .b      (mm_b),
    .n      (n_reg),
    .nprime0(nprime_q),
    .result (mm_res),
    .done   (mm_done),
    .state  (state)
  );

`ifdef MODEXP_ASSERT_EN
  logic [DW-1:0] np_check;
  assign np_check = nprime0 * n_reg[DW-1:0];
  a_n_odd:   assert property (@(posedge clk) disable iff (reset) (st_q == LOAD_N) |-> n_reg[0]);
  a_nprime:  assert property (@(posedge clk) disable iff (reset) (st_q == LOAD_N) |-> (np_check == '1));
  a_st_rng:  assert property (@(posedge clk) disable iff (reset) (st_q <= TERMINAL));
`endif

endmodule

// File: tb/tb_mod_exp.sv
// Self-checking bench for mod_exp: fixed RSA vectors, randomized operands vs a big-integer model,
// mid-run reset, load stall with early startCompute, and a long hold in COMPLETE.
module tb_mod_exp;

  localparam int DW     = 64;
  localparam int NW     = 4;
  localparam int W      = DW * NW;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] m_buf = '0, e_buf = '0, n_buf = '0, r_buf = '0, t_buf = '0, nprime0 = '0;
  logic          startInput = 1'b0, startCompute = 1'b0, getResult = 1'b0;
  logic [4:0]    exp_state;
  logic [3:0]    state;
  logic [DW-1:0] res_out;

  always #5 clk = ~clk;

  mod_exp #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset),
    .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
    .nprime0(nprime0), .startInput(startInput), .startCompute(startCompute),
    .getResult(getResult), .exp_state(exp_state), .state(state), .res_out(res_out)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- reference model: plain big-integer arithmetic ----
  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] n);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, n};
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] powmod(input logic [W-1:0] m, input logic [W-1:0] e,
                                          input logic [W-1:0] n);
    logic [W-1:0] acc;
    acc = W'(1) % n;
    for (int k = W - 1; k >= 0; k--) begin
      acc = mulmod(acc, acc, n);
      if (e[k]) acc = mulmod(acc, m, n);
    end
    return acc;
  endfunction

  function automatic logic [W-1:0] host_r(input logic [W-1:0] n);
    logic [2*W-1:0] big;
    big = '0;
    big[W] = 1'b1;
    big = big % {{W{1'b0}}, n};
    return big[W-1:0];
  endfunction

  function automatic logic [DW-1:0] host_np(input logic [DW-1:0] n0);
    logic [DW-1:0] x;
    x = n0;
    for (int k = 0; k < 6; k++) x = x * (DW'(2) - n0 * x);
    return -x;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    startInput = 1'b0;
    startCompute = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic load(input string tag, input logic [W-1:0] m, input logic [W-1:0] e,
                      input logic [W-1:0] n, input bit stall);
    logic [W-1:0] r, t;
    r = host_r(n);
    t = mulmod(r, r, n);
    nprime0 = host_np(n[DW-1:0]);
    startInput = 1'b1;
    @(posedge clk); #1;
    for (int w = 0; w < NW; w++) begin
      if (stall && w == 1) begin
        startInput = 1'b0;
        startCompute = 1'b1;
        repeat (3) @(posedge clk);
        #1 check({tag, ":stall"}, W'(exp_state), W'(1));
        startCompute = 1'b0;
        startInput = 1'b1;
      end
      m_buf = m[w*DW +: DW];
      e_buf = e[w*DW +: DW];
      n_buf = n[w*DW +: DW];
      r_buf = r[w*DW +: DW];
      t_buf = t[w*DW +: DW];
      @(posedge clk); #1;
    end
    startInput = 1'b0;
    @(posedge clk); #1;
    check({tag, ":wait"}, W'(exp_state), W'(3));
  endtask

  task automatic wait_state(input string tag, input logic [4:0] target);
    int cyc;
    cyc = 0;
    while (exp_state != target && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ":reach"}, W'(exp_state), W'(target));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] e,
                        input logic [W-1:0] n, input logic [W-1:0] c_exp,
                        input int hold, input bit stall);
    int bad;
    do_reset();
    load(tag, m, e, n, stall);
    startCompute = 1'b1;
    @(posedge clk); #1;
    startCompute = 1'b0;
    wait_state(tag, 5'd9);
    if (hold > 0) begin
      bad = 0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (exp_state != 5'd9 || res_out != '0) bad++;
      end
      check({tag, ":hold"}, W'(bad), W'(0));
    end
    startCompute = 1'b1;
    @(posedge clk); #1;
    startCompute = 1'b0;
    for (int j = 0; j < NW; j++) begin
      @(posedge clk); #1;
      check($sformatf("%s:word%0d", tag, j), W'(res_out), W'(c_exp[j*DW +: DW]));
    end
    repeat (3) @(posedge clk);
    #1 check({tag, ":terminal"}, W'(exp_state), W'(11));
    check({tag, ":hold_last"}, W'(res_out), W'(c_exp[(NW-1)*DW +: DW]));
  endtask

  typedef struct {
    logic [W-1:0] m;
    logic [W-1:0] e;
    logic [W-1:0] n;
    logic [W-1:0] c;
  } vec_t;

  initial begin
    vec_t tbl [5];
    logic [W-1:0] rm, re, rn;

    tbl[0] = '{W'(8),  W'(13), W'(77), W'(50)};
    tbl[1] = '{W'(50), W'(37), W'(77), W'(8)};
    tbl[2] = '{W'(5),  W'(0),  W'(77), W'(1)};
    tbl[3] = '{W'(76), W'(1),  W'(77), W'(76)};
    tbl[4] = '{W'(0),  W'(5),  W'(77), W'(0)};

    do_reset();
    check("reset:exp_state", W'(exp_state), W'(0));
    check("reset:state", W'(state), W'(0));
    check("reset:res_out", W'(res_out), W'(0));

    for (int v = 0; v < 5; v++)
      run_op($sformatf("vec%0d", v), tbl[v].m, tbl[v].e, tbl[v].n, tbl[v].c,
             (v == 0) ? 100 : 0, (v == 1));

    // Full-width operands against the reference model.
    for (int v = 0; v < 4; v++) begin
      for (int w = 0; w < W / 32; w++) begin
        rn[w*32 +: 32] = $urandom;
        rm[w*32 +: 32] = $urandom;
      end
      rn[W-1] = 1'b1;
      rn[0]   = 1'b1;
      rm      = rm % rn;
      re      = (v == 0) ? W'(24'hf3e7af) : W'($urandom_range(1, 65535));
      run_op($sformatf("rand%0d", v), rm, re, rn, powmod(rm, re, rn), 0, 1'b0);
    end

    // Reset while squaring must abort cleanly and allow a fresh run.
    do_reset();
    load("abort", tbl[0].m, tbl[0].e, tbl[0].n, 1'b0);
    startCompute = 1'b1;
    @(posedge clk); #1;
    startCompute = 1'b0;
    wait_state("abort", 5'd6);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("abort:exp_state", W'(exp_state), W'(0));
    check("abort:state", W'(state), W'(0));
    check("abort:res_out", W'(res_out), W'(0));
    reset = 1'b0;
    run_op("reload", tbl[0].m, tbl[0].e, tbl[0].n, tbl[0].c, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
